// File: rtl/switch_pkg.sv
// Shared constants for the switch input stage.
package switch_pkg;
    localparam int SW_WIDTH            = 32;
    localparam int SW_SAMPLE_DIV_DEF   = 50000;
    localparam int SW_STABLE_COUNT_DEF = 10;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-FF synchroniser, then an accept-after-N-differing-samples filter.
module switch_debounce_bit
    import switch_pkg::*;
#(
    parameter int STABLE_COUNT = SW_STABLE_COUNT_DEF
) (
    input  logic iClk,
    input  logic iReset_n,
    input  logic iRaw,
    input  logic iTick,
    output logic oDeb,
    output logic oUpd
);
    localparam int CW = $clog2(STABLE_COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_COUNT - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          upd;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
        end else begin
            sync1_q <= iRaw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
        end
    end

    // Any sample matching the current level restarts the run of differing samples.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        upd   = 1'b0;
        if (iTick) begin
            if (sync2_q == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q == LAST) begin
                deb_d = sync2_q;
                cnt_d = '0;
                upd   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign oDeb = deb_q;
    assign oUpd = upd;
endmodule

// File: rtl/switch_debounce.sv
// Switch register input stage: shared sample prescaler, per-bit debouncers, change flags.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int WIDTH        = SW_WIDTH,
    parameter int SAMPLE_DIV   = SW_SAMPLE_DIV_DEF,
    parameter int STABLE_COUNT = SW_STABLE_COUNT_DEF
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic [WIDTH-1:0] iSwitches_raw,
    input  logic             iClear,
    output logic [WIDTH-1:0] oSwitches_data,
    output logic             oChanged,
    output logic [WIDTH-1:0] oChange_mask
);
    localparam int PW = cnt_width(SAMPLE_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] deb, upd;

    // With SAMPLE_DIV=1 the counter sits at 0 and every cycle is a tick.
    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        presc_d   = tick ? '0 : presc_q + 1'b1;
        changed_d = |upd;
        mask_d    = (iClear ? '0 : mask_q) | upd;
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            presc_q   <= '0;
            changed_q <= 1'b0;
            mask_q    <= '0;
        end else begin
            presc_q   <= presc_d;
            changed_q <= changed_d;
            mask_q    <= mask_d;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        switch_debounce_bit #(
            .STABLE_COUNT(STABLE_COUNT)
        ) u_bit (
            .iClk    (iClk),
            .iReset_n(iReset_n),
            .iRaw    (iSwitches_raw[gi]),
            .iTick   (tick),
            .oDeb    (deb[gi]),
            .oUpd    (upd[gi])
        );
    end

    assign oSwitches_data = deb;
    assign oChanged       = changed_q;
    assign oChange_mask   = mask_q;
endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with WIDTH=8, SAMPLE_DIV=4, STABLE_COUNT=3.
module tb_switch_debounce;
    logic       iClk = 1'b0;
    logic       iReset_n;
    logic [7:0] iSwitches_raw;
    logic       iClear;
    logic [7:0] oSwitches_data;
    logic       oChanged;
    logic [7:0] oChange_mask;

    int checks = 0;
    int errors = 0;
    int cyc;

    switch_debounce #(.WIDTH(8), .SAMPLE_DIV(4), .STABLE_COUNT(3)) dut (
        .iClk          (iClk),
        .iReset_n      (iReset_n),
        .iSwitches_raw (iSwitches_raw),
        .iClear        (iClear),
        .oSwitches_data(oSwitches_data),
        .oChanged      (oChanged),
        .oChange_mask  (oChange_mask)
    );

    always #10 iClk = ~iClk;

    // Edges since reset release; prescaler ticks land on edges with cyc%4==0.
    always @(posedge iClk or negedge iReset_n)
        if (!iReset_n) cyc <= 0;
        else           cyc <= cyc + 1;

    typedef struct {
        logic [7:0] raw;
        logic [7:0] exp_data;
        logic [7:0] exp_mask;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Waits (bounded) for the oChanged pulse; data must hold its old value until then.
    task automatic wait_upd(input logic [7:0] old, output int n);
        logic held;
        held = 1'b1;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge iClk);
            if (oChanged) begin
                n = i;
                break;
            end
            if (oSwitches_data !== old) held = 1'b0;
        end
        chk("hold_old", {31'd0, held}, 32'd1);
    endtask

    task automatic clear_pulse();
        iClear = 1'b1;
        @(negedge iClk);
        iClear = 1'b0;
        chk("mask_cleared", {24'd0, oChange_mask}, 32'd0);
    endtask

    initial begin
        int n, c0, k, pulses;
        logic [7:0] prev;
        logic bad;

        vecs[0] = '{8'h00, 8'h00, 8'hFF};
        vecs[1] = '{8'h01, 8'h01, 8'h01};
        vecs[2] = '{8'h00, 8'h00, 8'h01};
        vecs[3] = '{8'hA5, 8'hA5, 8'hA5};
        vecs[4] = '{8'h00, 8'h00, 8'hA5};

        // 1: switches high through reset
        iReset_n = 1'b0;
        iSwitches_raw = 8'hFF;
        iClear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            chk("rst_outputs", {15'd0, oSwitches_data, oChanged, oChange_mask}, 32'd0);
        end
        iReset_n = 1'b1;
        wait_upd(8'h00, n);
        chk_rng("rst_latency", n, 11, 15);
        chk("rst_data", {24'd0, oSwitches_data}, 32'hFF);
        chk("rst_mask", {24'd0, oChange_mask}, 32'hFF);
        @(negedge iClk);
        chk("rst_pulse_one", {31'd0, oChanged}, 32'd0);

        // 2/4: clean and simultaneous edges
        prev = 8'hFF;
        for (int v = 0; v < 5; v++) begin
            clear_pulse();
            iSwitches_raw = vecs[v].raw;
            wait_upd(prev, n);
            chk_rng("vec_latency", n, 11, 15);
            chk("vec_data", {24'd0, oSwitches_data}, {24'd0, vecs[v].exp_data});
            @(negedge iClk);
            chk("vec_pulse_one", {31'd0, oChanged}, 32'd0);
            chk("vec_mask", {24'd0, oChange_mask}, {24'd0, vecs[v].exp_mask});
            prev = vecs[v].exp_data;
        end

        // 3: bit0 toggles every 3 cycles, then settles high
        clear_pulse();
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) iSwitches_raw[0] = ~iSwitches_raw[0];
            @(negedge iClk);
            if (oChanged || oSwitches_data !== 8'h00) bad = 1'b1;
        end
        chk("bounce_no_change", {31'd0, bad}, 32'd0);
        iSwitches_raw = 8'h01;
        wait_upd(8'h00, n);
        chk_rng("bounce_latency", n, 1, 15);
        chk("bounce_data", {24'd0, oSwitches_data}, 32'h01);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge iClk);
            if (oChanged) pulses++;
        end
        chk("bounce_single_pulse", pulses, 0);
        chk("bounce_mask", {24'd0, oChange_mask}, 32'h01);

        // 5: clear coincident with bit1 update; third differing tick is k+8
        iSwitches_raw = 8'h03;
        c0 = cyc;
        k = ((c0 + 6) / 4) * 4;
        while (cyc < k + 7) @(negedge iClk);
        chk("pre_clear_mask", {24'd0, oChange_mask}, 32'h01);
        iClear = 1'b1;
        @(negedge iClk);
        iClear = 1'b0;
        chk("clr_upd_changed", {31'd0, oChanged}, 32'd1);
        chk("clr_upd_mask", {24'd0, oChange_mask}, 32'h02);
        chk("clr_upd_data", {24'd0, oSwitches_data}, 32'h03);

        // 6: reset after two counted ticks on bit2
        iSwitches_raw = 8'h07;
        c0 = cyc;
        k = ((c0 + 6) / 4) * 4;
        while (cyc < k + 4) @(negedge iClk);
        chk("pre_rst_data", {24'd0, oSwitches_data}, 32'h03);
        iReset_n = 1'b0;
        @(negedge iClk);
        chk("midrst_outputs", {15'd0, oSwitches_data, oChanged, oChange_mask}, 32'd0);
        iReset_n = 1'b1;
        wait_upd(8'h00, n);
        chk_rng("midrst_latency", n, 11, 15);
        chk("midrst_data", {24'd0, oSwitches_data}, 32'h07);
        chk("midrst_mask", {24'd0, oChange_mask}, 32'h07);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
